// File: rtl/pmem_pkg.sv
// Shared types and constants for the pmem burst responder and its line store.
package pmem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RBURST,
    ST_WBURST,
    ST_DONE
  } pmem_state_t;

  localparam int PMEM_BEATS       = 4;
  localparam int PMEM_BEAT_W      = 64;
  localparam int PMEM_LINE_OFFSET = 5;
  localparam int PMEM_ADDR_W      = 32;
  localparam int PMEM_BEAT_SEL_W  = $clog2(PMEM_BEATS);

  localparam logic [PMEM_BEAT_SEL_W-1:0] PMEM_LAST_BEAT = PMEM_BEAT_SEL_W'(PMEM_BEATS - 1);

endpackage

// File: rtl/pmem_burst_responder_if.sv
// Requester-side pmem burst bus: request, address, write beats and the beat strobe.
interface pmem_burst_responder_if;
  import pmem_pkg::*;

  logic                   pmem_read;
  logic                   pmem_write;
  logic [PMEM_ADDR_W-1:0] pmem_address;
  logic [PMEM_BEAT_W-1:0] pmem_wdata;
  logic                   pmem_resp;
  logic [PMEM_BEAT_W-1:0] pmem_rdata;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata
  );

endinterface

// File: rtl/pmem_line_array.sv
// Line store addressed by {line index, beat}; beat-granular writes, registered one-beat read.
module pmem_line_array
  import pmem_pkg::*;
#(
  parameter int IDX_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IDX_WIDTH-1:0]       index,
  input  logic [PMEM_BEAT_SEL_W-1:0] beat_sel,
  input  logic                       we,
  input  logic                       re,
  input  logic [PMEM_BEAT_W-1:0]     wdata,
  output logic [PMEM_BEAT_W-1:0]     rdata
);

  localparam int DEPTH = (2 ** IDX_WIDTH) * PMEM_BEATS;

  logic [PMEM_BEAT_W-1:0]               mem [DEPTH];
  logic [IDX_WIDTH+PMEM_BEAT_SEL_W-1:0] addr;

  assign addr = {index, beat_sel};

  // Storage is deliberately left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/pmem_burst_responder.sv
// Memory end of the pmem burst link: latency wait, four-beat line transfer, stat counters.
module pmem_burst_responder
  import pmem_pkg::*;
#(
  parameter int IDX_WIDTH = 8,
  parameter int LATENCY   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  pmem_burst_responder_if.slave   bus,
  output logic [31:0]             rd_count,
  output logic [31:0]             wr_count,
  output logic                    proto_err
);

  localparam logic [7:0] LAT_INIT = 8'(LATENCY - 1);

  pmem_state_t                state_q, state_d;
  logic [7:0]                 lat_q, lat_d;
  logic [PMEM_BEAT_SEL_W-1:0] beat_q, beat_d;
  logic [IDX_WIDTH-1:0]       idx_q, idx_d;
  logic                       wr_dir_q, wr_dir_d;
  logic [31:0]                rd_count_d, wr_count_d;
  logic                       proto_err_d;

  logic                       req_any;
  logic                       held;
  logic                       accept;
  logic                       arr_we;
  logic                       arr_re;
  logic [PMEM_BEAT_SEL_W-1:0] arr_beat;
  logic                       resp;
  logic [PMEM_BEAT_W-1:0]     arr_rdata;
  logic                       unused_addr;

  assign req_any     = bus.pmem_read | bus.pmem_write;
  assign held        = wr_dir_q ? bus.pmem_write : bus.pmem_read;
  assign unused_addr = ^bus.pmem_address;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      lat_q     <= '0;
      beat_q    <= '0;
      idx_q     <= '0;
      wr_dir_q  <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      beat_q    <= beat_d;
      idx_q     <= idx_d;
      wr_dir_q  <= wr_dir_d;
      rd_count  <= rd_count_d;
      wr_count  <= wr_count_d;
      proto_err <= proto_err_d;
    end
  end

  // The array read is issued one cycle ahead of each read beat so that the
  // registered rdata lines up with the beat strobe. DONE may accept a new
  // request at its closing edge, giving one line per LATENCY+5 cycles.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    beat_d      = beat_q;
    idx_d       = idx_q;
    wr_dir_d    = wr_dir_q;
    rd_count_d  = rd_count;
    wr_count_d  = wr_count;
    proto_err_d = proto_err;
    arr_we      = 1'b0;
    arr_re      = 1'b0;
    arr_beat    = beat_q;
    resp        = 1'b0;
    accept      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        accept = req_any;
      end

      ST_WAIT: begin
        if (!held) begin
          state_d     = ST_IDLE;
          proto_err_d = 1'b1;
        end else if (lat_q == 8'd0) begin
          state_d = wr_dir_q ? ST_WBURST : ST_RBURST;
          beat_d  = '0;
          if (!wr_dir_q) begin
            arr_re   = 1'b1;
            arr_beat = '0;
          end
        end else begin
          lat_d = lat_q - 8'd1;
        end
      end

      ST_RBURST: begin
        resp = 1'b1;
        if (!held) begin
          proto_err_d = 1'b1;
        end
        if (beat_q == PMEM_LAST_BEAT) begin
          state_d = ST_DONE;
        end else begin
          beat_d   = beat_q + 1'b1;
          arr_re   = 1'b1;
          arr_beat = beat_q + 1'b1;
        end
      end

      ST_WBURST: begin
        resp   = 1'b1;
        arr_we = rst;
        if (!held) begin
          proto_err_d = 1'b1;
        end
        if (beat_q == PMEM_LAST_BEAT) begin
          state_d = ST_DONE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        if (wr_dir_q) begin
          wr_count_d = wr_count + 32'd1;
        end else begin
          rd_count_d = rd_count + 32'd1;
        end
        accept = req_any;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      state_d  = ST_WAIT;
      lat_d    = LAT_INIT;
      idx_d    = bus.pmem_address[PMEM_LINE_OFFSET +: IDX_WIDTH];
      wr_dir_d = bus.pmem_write & ~bus.pmem_read;
      if (bus.pmem_read && bus.pmem_write) begin
        proto_err_d = 1'b1;
      end
    end
  end

  pmem_line_array #(
    .IDX_WIDTH (IDX_WIDTH)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .index    (idx_q),
    .beat_sel (arr_beat),
    .we       (arr_we),
    .re       (arr_re),
    .wdata    (bus.pmem_wdata),
    .rdata    (arr_rdata)
  );

  assign bus.pmem_resp  = resp;
  assign bus.pmem_rdata = arr_rdata;

endmodule
